// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length and sequencer state encodings, round-constant counts
// and an elaboration-time round-constant helper.
`default_nettype none

package aes_pkg;

  localparam logic [7:0] AES_POLY    = 8'h1B;
  localparam int         NR_RCON_128 = 10;
  localparam int         NR_RCON_192 = 8;
  localparam int         NR_RCON_256 = 7;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_RSV = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [7:0] xtime_f(input logic [7:0] a, input logic [7:0] poly);
    return {a[6:0], 1'b0} ^ (a[7] ? poly : 8'h00);
  endfunction

  // Rcon[n] for an arbitrary field polynomial: n-1 doublings of 8'h01.
  function automatic logic [7:0] rcon_at(input logic [7:0] poly, input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < 16; i++) begin
      if (i < n) r = xtime_f(r, poly);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gf_xtime.sv
// GF(2^8) multiply-by-x (INV=0) or multiply-by-x^-1 (INV=1) over x^8 + POLY.
`default_nettype none

module gf_xtime #(
  parameter logic [7:0] POLY = 8'h1B,
  parameter bit         INV  = 1'b0
) (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  generate
    if (INV) begin : g_inv
      // Odd values had the reduction applied on the way up, so undo it before shifting down.
      assign y_o = a_i[0] ? (((a_i ^ POLY) >> 1) | 8'h80) : (a_i >> 1);
    end else begin : g_fwd
      assign y_o = {a_i[6:0], 1'b0} ^ (a_i[7] ? POLY : 8'h00);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rcon_seq_gen.sv
// Sequential AES round-constant generator streaming Rcon[1..N] over valid/ready.
// Define RCON_INV_EN to add the dir port and reverse (Rcon[N..1]) streaming.
`default_nettype none

module rcon_seq_gen
  import aes_pkg::*;
#(
  parameter logic [7:0] POLY  = AES_POLY,
  parameter int         IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       key_len,
`ifdef RCON_INV_EN
  input  logic             dir,
`endif
  input  logic             rcon_ready,
  output logic [7:0]       rcon_out,
  output logic [IDX_W-1:0] rcon_idx,
  output logic             rcon_valid,
  output logic             rcon_last,
  output logic             done
);

  localparam logic [IDX_W-1:0] N128 = IDX_W'(NR_RCON_128);
  localparam logic [IDX_W-1:0] N192 = IDX_W'(NR_RCON_192);
  localparam logic [IDX_W-1:0] N256 = IDX_W'(NR_RCON_256);
  localparam logic [IDX_W-1:0] IDX1 = IDX_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic             dir_q, dir_d;

  logic [IDX_W-1:0] w_n_sel;
  logic [7:0]       w_fwd;
  logic [7:0]       w_step;
  logic [7:0]       w_first;
  logic [IDX_W-1:0] w_first_idx;
  logic             w_dir_in;
  logic             w_xfer;

  gf_xtime #(.POLY(POLY), .INV(1'b0)) u_xtime_fwd (.a_i(rcon_q), .y_o(w_fwd));

  always_comb begin
    w_n_sel = N128;
    case (key_len_e'(key_len))
      KL_192:  w_n_sel = N192;
      KL_256:  w_n_sel = N256;
      default: w_n_sel = N128;
    endcase
  end

`ifdef RCON_INV_EN
  localparam logic [7:0] RINIT_128 = rcon_at(POLY, NR_RCON_128);
  localparam logic [7:0] RINIT_192 = rcon_at(POLY, NR_RCON_192);
  localparam logic [7:0] RINIT_256 = rcon_at(POLY, NR_RCON_256);

  logic [7:0] w_inv;
  logic [7:0] w_rinit;

  gf_xtime #(.POLY(POLY), .INV(1'b1)) u_xtime_inv (.a_i(rcon_q), .y_o(w_inv));

  always_comb begin
    w_rinit = RINIT_128;
    case (key_len_e'(key_len))
      KL_192:  w_rinit = RINIT_192;
      KL_256:  w_rinit = RINIT_256;
      default: w_rinit = RINIT_128;
    endcase
  end

  assign w_dir_in    = dir;
  assign w_step      = dir_q ? w_inv : w_fwd;
  assign w_first     = dir ? w_rinit : 8'h01;
  assign w_first_idx = dir ? w_n_sel : IDX1;
`else
  assign w_dir_in    = 1'b0;
  assign w_step      = w_fwd;
  assign w_first     = 8'h01;
  assign w_first_idx = IDX1;
`endif

  assign rcon_out   = rcon_q;
  assign rcon_idx   = idx_q;
  assign rcon_valid = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign rcon_last  = rcon_valid && (dir_q ? (idx_q == IDX1) : (idx_q == n_q));
  assign w_xfer     = rcon_valid && rcon_ready;

  always_comb begin
    state_d = state_q;
    rcon_d  = rcon_q;
    idx_d   = idx_q;
    n_d     = n_q;
    dir_d   = dir_q;
    // A start overrides everything, including a coincident final transfer.
    if (start) begin
      state_d = ST_RUN;
      n_d     = w_n_sel;
      dir_d   = w_dir_in;
      rcon_d  = w_first;
      idx_d   = w_first_idx;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (w_xfer) begin
            if (rcon_last) begin
              state_d = ST_DONE;
            end else begin
              rcon_d = w_step;
              idx_d  = dir_q ? (idx_q - IDX1) : (idx_q + IDX1);
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rcon_q  <= 8'h00;
      idx_q   <= '0;
      n_q     <= N128;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcon_q  <= rcon_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      dir_q   <= dir_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rcon_seq_gen.sv
// Self-checking bench for rcon_seq_gen; reverse-mode sequences run when RCON_INV_EN is defined.
`default_nettype none

module tb_rcon_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] key_len;
`ifdef RCON_INV_EN
  logic       dir;
`endif
  logic       rcon_ready;
  logic [7:0] rcon_out;
  logic [3:0] rcon_idx;
  logic       rcon_valid;
  logic       rcon_last;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rcon_seq_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_len    (key_len),
`ifdef RCON_INV_EN
    .dir        (dir),
`endif
    .rcon_ready (rcon_ready),
    .rcon_out   (rcon_out),
    .rcon_idx   (rcon_idx),
    .rcon_valid (rcon_valid),
    .rcon_last  (rcon_last),
    .done       (done)
  );

  wire [14:0] obs = {rcon_valid, rcon_last, done, rcon_idx, rcon_out};

  // Rcon[i] = x^(i-1) in GF(2^8) mod x^8+x^4+x^3+x+1, by plain integer doubling.
  function automatic logic [7:0] rcon_ref(input int i);
    int v = 1;
    for (int j = 1; j < i; j++) begin
      v = v * 2;
      if (v >= 256) v = v ^ 'h11B;
    end
    return v[7:0];
  endfunction

  function automatic int n_of(input logic [1:0] kl);
    case (kl)
      2'b01:   return 8;
      2'b10:   return 7;
      default: return 10;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic pulse_start(input logic [1:0] kl, input logic d);
    start   = 1'b1;
    key_len = kl;
`ifdef RCON_INV_EN
    dir = d;
`else
    if (d) $display("note: reverse request ignored in forward-only build");
`endif
    @(negedge clk);
    start   = 1'b0;
    key_len = 2'($urandom);
`ifdef RCON_INV_EN
    dir = 1'($urandom);
`endif
  endtask

  // rmode: 0 ready high, 1 ready toggling 1010.., 2 random ready.
  // stop_at: return as soon as that index is presented, without consuming it.
  task automatic stream(input logic [1:0] kl, input logic d, input int rmode,
                        input int stop_at, input string tag);
    int   n = n_of(kl);
    int   k = 0;
    int   cyc = 0;
    int   ix;
    int   last_ix;
    logic r;
    while (k < n && cyc <= 400) begin
      ix = d ? n - k : k + 1;
      if (stop_at == ix) return;
      r = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'((cyc % 2) == 0) : 1'($urandom);
      rcon_ready = r;
      chk(tag, obs, {1'b1, 1'(k == n - 1), 1'b0, 4'(ix), rcon_ref(ix)});
      @(negedge clk);
      cyc++;
      if (r) k++;
    end
    checks++;
    assert (k == n) else begin
      errors++;
      $error("FAIL %s_timeout observed=%0d expected=%0d words", tag, k, n);
    end
    if (k != n) return;
    last_ix    = d ? 1 : n;
    rcon_ready = 1'($urandom);
    chk({tag, "_done"}, {5'b0, rcon_valid, done, rcon_out}, {5'b0, 1'b0, 1'b1, rcon_ref(last_ix)});
    @(negedge clk);
    chk({tag, "_idle"}, {5'b0, rcon_valid, done, rcon_out}, {5'b0, 1'b0, 1'b0, rcon_ref(last_ix)});
  endtask

  initial begin
    logic [1:0] kl;
    logic       d;
    rst_n      = 1'b0;
    start      = 1'b0;
    key_len    = 2'b00;
    rcon_ready = 1'b0;
`ifdef RCON_INV_EN
    dir = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset", obs, 15'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", obs, 15'h0);

    pulse_start(2'b00, 1'b0);
    stream(2'b00, 1'b0, 0, 0, "fwd128");

    pulse_start(2'b10, 1'b0);
    stream(2'b10, 1'b0, 1, 0, "fwd256_toggle");

`ifdef RCON_INV_EN
    pulse_start(2'b01, 1'b1);
    stream(2'b01, 1'b1, 0, 0, "rev192");
    pulse_start(2'b00, 1'b1);
    stream(2'b00, 1'b1, 2, 0, "rev128_rand");
`endif

    // Restart at idx 4 with a coincident transfer; only the second run may pulse done.
    pulse_start(2'b00, 1'b0);
    stream(2'b00, 1'b0, 0, 4, "abort_first");
    rcon_ready = 1'b1;
    pulse_start(2'b00, 1'b0);
    stream(2'b00, 1'b0, 0, 0, "abort_restart");

    // Restart on the final transfer of an AES-256 run.
    pulse_start(2'b10, 1'b0);
    stream(2'b10, 1'b0, 0, 7, "last_first");
    rcon_ready = 1'b1;
    pulse_start(2'b01, 1'b0);
    stream(2'b01, 1'b0, 2, 0, "last_restart");

    // Reset mid-sequence, then reserved key length behaves as AES-128.
    pulse_start(2'b00, 1'b0);
    stream(2'b00, 1'b0, 0, 6, "pre_reset");
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset", obs, 15'h0);
    rst_n = 1'b1;
    pulse_start(2'b11, 1'b0);
    stream(2'b11, 1'b0, 0, 0, "kl_reserved");

    repeat (8) begin
      kl = 2'($urandom);
`ifdef RCON_INV_EN
      d = 1'($urandom);
`else
      d = 1'b0;
`endif
      pulse_start(kl, d);
      stream(kl, d, 2, 0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
